// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Round-robin burst write arbiter in front of a FIFO, with a
//            pass-through read enable and a sticky full/empty error flag.
//            Optional stall counter enabled by macro FIFO_ARB_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     last,
    input  logic [NREQ*DW-1:0]  wdata,
    output logic [NREQ-1:0]     gnt,
    input  logic                fifo_full,
    input  logic                fifo_empty,
    output logic                fifo_wr_en,
    output logic [DW-1:0]       fifo_wdata,
    input  logic                rd_req,
    output logic                fifo_rd_en,
    output logic                flag_err,
    output logic [15:0]         stall_cnt
);

    localparam int         c_PW    = $clog2(NREQ);
    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_BURST = 1'b1;

    logic [0:0]      r_state, w_state_nxt;
    logic [c_PW-1:0] r_rr_ptr, w_rr_ptr_nxt;
    logic [c_PW-1:0] r_owner, w_owner_nxt;
    logic [3:0]      r_beat_cnt, w_beat_cnt_nxt;
    logic            r_flag_err;
    logic [c_PW-1:0] w_winner;
    logic            w_found;
    logic [NREQ-1:0] w_gnt;

    function automatic logic [c_PW-1:0] f_next_ptr(input logic [c_PW-1:0] p);
        if (p == c_PW'(NREQ - 1))
            return '0;
        return p + c_PW'(1);
    endfunction

    // Cyclic upward search for the first active request starting at rr_ptr.
    always_comb begin
        int unsigned v_idx;
        w_winner = r_rr_ptr;
        w_found  = 1'b0;
        v_idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            v_idx = (int'(r_rr_ptr) + k) % NREQ;
            if (!w_found && req[v_idx]) begin
                w_found  = 1'b1;
                w_winner = c_PW'(v_idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= c_IDLE;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_owner    <= w_owner_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    // fifo_full (which also covers the full&&empty error case) freezes all state.
    always_comb begin
        w_state_nxt    = r_state;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_owner_nxt    = r_owner;
        w_beat_cnt_nxt = r_beat_cnt;
        case (r_state)
            c_IDLE: begin
                if (w_found && !fifo_full) begin
                    if (last[w_winner] || (MAX_BURST == 1)) begin
                        w_rr_ptr_nxt = f_next_ptr(w_winner);
                    end else begin
                        w_state_nxt    = c_BURST;
                        w_owner_nxt    = w_winner;
                        w_beat_cnt_nxt = 4'd1;
                    end
                end
            end
            c_BURST: begin
                if (!fifo_full) begin
                    if (!req[r_owner]) begin
                        w_state_nxt  = c_IDLE;
                        w_rr_ptr_nxt = f_next_ptr(r_owner);
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + 4'd1;
                        if (last[r_owner] || (r_beat_cnt + 4'd1 == 4'(MAX_BURST))) begin
                            w_state_nxt  = c_IDLE;
                            w_rr_ptr_nxt = f_next_ptr(r_owner);
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Outputs are gated by rst so they drop immediately, without a clock edge.
    always_comb begin
        w_gnt      = '0;
        fifo_wdata = '0;
        if (rst && !fifo_full) begin
            if (r_state == c_IDLE) begin
                if (w_found)
                    w_gnt[w_winner] = 1'b1;
            end else begin
                w_gnt[r_owner] = req[r_owner];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i])
                fifo_wdata = wdata[i*DW +: DW];
        end
    end

    assign gnt        = w_gnt;
    assign fifo_wr_en = |w_gnt;
    assign fifo_rd_en = rst & rd_req & ~fifo_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_flag_err <= 1'b0;
        else if (fifo_full && fifo_empty)
            r_flag_err <= 1'b1;
    end

    assign flag_err = r_flag_err;

`ifdef FIFO_ARB_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_stall_cnt <= '0;
        else if ((|req) && fifo_full && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Brief    : Scoreboard-based self-checking bench for fifo_wr_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int NREQ      = 4;
    localparam int DW        = 8;
    localparam int MAX_BURST = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ-1:0]     last;
    logic [NREQ*DW-1:0]  wdata;
    logic [NREQ-1:0]     gnt;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_wr_en;
    logic [DW-1:0]       fifo_wdata;
    logic                rd_req;
    logic                fifo_rd_en;
    logic                flag_err;
    logic [15:0]         stall_cnt;

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        logic [NREQ-1:0] gnt;
        logic [DW-1:0]   data;
        logic            rd;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .last       (last),
        .wdata      (wdata),
        .gnt        (gnt),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .fifo_wr_en (fifo_wr_en),
        .fifo_wdata (fifo_wdata),
        .rd_req     (rd_req),
        .fifo_rd_en (fifo_rd_en),
        .flag_err   (flag_err),
        .stall_cnt  (stall_cnt)
    );

    function automatic logic [DW-1:0] exp_data(input logic [NREQ-1:0] g, input logic [NREQ*DW-1:0] d);
        for (int i = 0; i < NREQ; i++)
            if (g[i]) return d[i*DW +: DW];
        return '0;
    endfunction

    task automatic do_reset();
        rst = 1'b0; req = '0; last = '0; wdata = '0;
        fifo_full = 1'b0; fifo_empty = 1'b0; rd_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; req = '1; last = '0; wdata = $urandom;
        fifo_full = 1'b0; fifo_empty = 1'b0; rd_req = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_run++;
        if (gnt !== 4'b0 || fifo_wr_en !== 1'b0 || fifo_wdata !== 8'h00 || fifo_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: gnt=%b wr_en=%b wdata=%h rd_en=%b, expected all zero",
                     gnt, fifo_wr_en, fifo_wdata, fifo_rd_en);
        end
        n_run++;
        if (flag_err !== 1'b0 || stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_regs: flag_err=%b stall_cnt=%0d, expected 0 and 0", flag_err, stall_cnt);
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            req = '1; last = '1; wdata = $urandom;
            e.gnt = 4'b0001 << (c % 4); e.data = exp_data(e.gnt, wdata); e.rd = 1'b0;
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            n_run++;
            if (gnt !== e.gnt || fifo_wr_en !== (|e.gnt) || fifo_wdata !== e.data || fifo_rd_en !== e.rd) begin
                n_fail++;
                $display("FAIL round_robin c%0d: gnt=%b wr_en=%b wdata=%h, expected gnt=%b wdata=%h",
                         c, gnt, fifo_wr_en, fifo_wdata, e.gnt, e.data);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_max_burst();
        exp_t e;
        logic [NREQ-1:0] r_tab [2][6];
        logic [NREQ-1:0] g_tab [2][6];
        // Pass 0: requester 2 alone; pass 1: others join and win after the burst cap.
        r_tab[0] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100};
        g_tab[0] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100};
        r_tab[1] = '{4'b0100, 4'b1101, 4'b1101, 4'b1101, 4'b1101, 4'b1101};
        g_tab[1] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b1000};
        for (int p = 0; p < 2; p++) begin
            do_reset();
            for (int c = 0; c < 6; c++) begin
                req = r_tab[p][c]; last = '0; wdata = $urandom;
                e.gnt = g_tab[p][c]; e.data = exp_data(e.gnt, wdata); e.rd = 1'b0;
                sb.push_back(e);
                @(negedge clk);
                e = sb.pop_front();
                n_run++;
                if (gnt !== e.gnt || fifo_wr_en !== (|e.gnt) || fifo_wdata !== e.data || fifo_rd_en !== e.rd) begin
                    n_fail++;
                    $display("FAIL max_burst p%0d c%0d: gnt=%b wr_en=%b wdata=%h, expected gnt=%b wdata=%h",
                             p, c, gnt, fifo_wr_en, fifo_wdata, e.gnt, e.data);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_full_stall();
        exp_t e;
        logic [NREQ-1:0] r_tab [8] = '{4'b0010, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011};
        logic            f_tab [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [NREQ-1:0] g_tab [8] = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            req = r_tab[c]; fifo_full = f_tab[c]; last = '0; wdata = $urandom;
            e.gnt = g_tab[c]; e.data = exp_data(e.gnt, wdata); e.rd = 1'b0;
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            n_run++;
            if (gnt !== e.gnt || fifo_wr_en !== (|e.gnt) || fifo_wdata !== e.data || fifo_rd_en !== e.rd) begin
                n_fail++;
                $display("FAIL full_stall c%0d: gnt=%b wr_en=%b wdata=%h, expected gnt=%b wdata=%h",
                         c, gnt, fifo_wr_en, fifo_wdata, e.gnt, e.data);
            end
            @(posedge clk); #1;
        end
        fifo_full = 1'b0;
    endtask

    task automatic test_read();
        exp_t e;
        logic            em_tab [3] = '{1'b1, 1'b0, 1'b0};
        logic [NREQ-1:0] r_tab  [3] = '{4'b0000, 4'b0000, 4'b0001};
        logic            rd_tab [3] = '{1'b0, 1'b1, 1'b1};
        do_reset();
        for (int c = 0; c < 3; c++) begin
            rd_req = 1'b1; fifo_empty = em_tab[c]; req = r_tab[c]; last = '1; wdata = $urandom;
            e.gnt = r_tab[c]; e.data = exp_data(e.gnt, wdata); e.rd = rd_tab[c];
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            n_run++;
            if (gnt !== e.gnt || fifo_wr_en !== (|e.gnt) || fifo_wdata !== e.data || fifo_rd_en !== e.rd) begin
                n_fail++;
                $display("FAIL read c%0d: rd_en=%b gnt=%b wdata=%h, expected rd_en=%b gnt=%b wdata=%h",
                         c, fifo_rd_en, gnt, fifo_wdata, e.rd, e.gnt, e.data);
            end
            @(posedge clk); #1;
        end
        rd_req = 1'b0;
    endtask

    task automatic test_flag_err();
        exp_t e;
        logic            f_tab  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic            em_tab [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [NREQ-1:0] g_tab  [6] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
        logic            rd_tab [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic            fe_tab [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            req = 4'b0001; last = '1; rd_req = 1'b1; wdata = $urandom;
            fifo_full = f_tab[c]; fifo_empty = em_tab[c];
            e.gnt = g_tab[c]; e.data = exp_data(e.gnt, wdata); e.rd = rd_tab[c];
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            n_run++;
            if (gnt !== e.gnt || fifo_wr_en !== (|e.gnt) || fifo_wdata !== e.data ||
                fifo_rd_en !== e.rd || flag_err !== fe_tab[c]) begin
                n_fail++;
                $display("FAIL flag_err c%0d: gnt=%b wr_en=%b rd_en=%b flag_err=%b, expected gnt=%b rd_en=%b flag_err=%b",
                         c, gnt, fifo_wr_en, fifo_rd_en, flag_err, e.gnt, e.rd, fe_tab[c]);
            end
            @(posedge clk); #1;
        end
        fifo_full = 1'b0; fifo_empty = 1'b0; rd_req = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        exp_t e;
        logic [NREQ-1:0] r_tab [3] = '{4'b0001, 4'b1000, 4'b1000};
        logic [NREQ-1:0] l_tab [3] = '{4'b0001, 4'b0000, 4'b0000};
        do_reset();
        // Move rr_ptr off zero, then open a burst owned by requester 3.
        for (int c = 0; c < 3; c++) begin
            req = r_tab[c]; last = l_tab[c]; wdata = $urandom;
            e.gnt = r_tab[c]; e.data = exp_data(e.gnt, wdata); e.rd = 1'b0;
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            n_run++;
            if (gnt !== e.gnt || fifo_wr_en !== (|e.gnt) || fifo_wdata !== e.data || fifo_rd_en !== e.rd) begin
                n_fail++;
                $display("FAIL mid_burst_pre c%0d: gnt=%b wdata=%h, expected gnt=%b wdata=%h",
                         c, gnt, fifo_wdata, e.gnt, e.data);
            end
            @(posedge clk); #1;
        end
        rd_req = 1'b1;
        rst = 1'b0;
        #1;
        n_run++;
        if (gnt !== 4'b0 || fifo_wr_en !== 1'b0 || fifo_wdata !== 8'h00 || fifo_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: gnt=%b wr_en=%b wdata=%h rd_en=%b, expected all zero",
                     gnt, fifo_wr_en, fifo_wdata, fifo_rd_en);
        end
        rd_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; req = 4'b1001; last = '0; wdata = $urandom;
        e.gnt = 4'b0001; e.data = exp_data(e.gnt, wdata); e.rd = 1'b0;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        n_run++;
        if (gnt !== e.gnt || fifo_wr_en !== (|e.gnt) || fifo_wdata !== e.data) begin
            n_fail++;
            $display("FAIL post_reset_arb: gnt=%b wdata=%h, expected gnt=%b wdata=%h", gnt, fifo_wdata, e.gnt, e.data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stall_cnt();
        logic [15:0] exp_cnt;
`ifdef FIFO_ARB_STALL_CNT_EN
        exp_cnt = 16'd5;
`else
        exp_cnt = 16'd0;
`endif
        do_reset();
        req = 4'b0001; last = '0; fifo_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_run++;
            if (gnt !== 4'b0 || fifo_wr_en !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_gate c%0d: gnt=%b wr_en=%b, expected 0000 and 0", c, gnt, fifo_wr_en);
            end
            @(posedge clk); #1;
        end
        req = '0; fifo_full = 1'b0;
        @(negedge clk);
        n_run++;
        if (stall_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL stall_cnt: got %0d, expected %0d", stall_cnt, exp_cnt);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_max_burst();
        test_full_stall();
        test_read();
        test_flag_err();
        test_reset_mid_burst();
        test_stall_cnt();
        if (sb.size() != 0) begin
            n_run++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have one clock and a reset that is asynchronous and active-low.
REQ-002 Parameter NREQ, default 4, SHALL set the number of write requesters (2..8).
REQ-003 Parameter DW, default 8, SHALL set the data width.
REQ-004 Parameter MAX_BURST, default 4, SHALL set the maximum beats per grant tenure (1..15).
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-low reset.
REQ-007 req  in  NREQ  per-requester write request.
REQ-008 last  in  NREQ  marks the requester's final beat of a burst.
REQ-009 wdata  in  NREQ*DW  requester data; slice i belongs to requester i.
REQ-010 gnt  out  NREQ  one-hot beat grant; a beat transfers in any cycle where gnt[i]=1.
REQ-011 fifo_full  in  1  FIFO full flag.
REQ-012 fifo_empty  in  1  FIFO empty flag.
REQ-013 fifo_wr_en  out  1  FIFO write enable.
REQ-014 fifo_wdata  out  DW  FIFO write data.
REQ-015 rd_req  in  1  consumer read request.
REQ-016 fifo_rd_en  out  1  FIFO read enable.
REQ-017 flag_err  out  1  sticky error: full and empty were seen high together.
REQ-018 stall_cnt  out  16  write-stall cycle count (see Configuration).

Function
REQ-019 The FSM SHALL have exactly two states, IDLE and BURST, plus registers rr_ptr, owner, and beat_cnt (4 bits).
REQ-020 In IDLE, winner SHALL be the first asserted req index found searching cyclically upward from rr_ptr.
REQ-021 In IDLE with any req and !fifo_full, gnt[winner] SHALL assert combinationally in the same cycle (zero latency).
REQ-022 After that IDLE beat: if last[winner] or MAX_BURST==1, the block SHALL stay in IDLE and set rr_ptr<=winner+1 mod NREQ; otherwise it SHALL enter BURST with owner<=winner and beat_cnt<=1.
REQ-023 In BURST, gnt[owner] SHALL equal req[owner]&!fifo_full, and all other gnt bits SHALL be 0.
REQ-024 A BURST beat SHALL increment beat_cnt.
REQ-025 A BURST beat with last[owner], or with beat_cnt+1==MAX_BURST, SHALL return the block to IDLE with rr_ptr<=owner+1 mod NREQ.
REQ-026 req[owner] low in BURST SHALL release the tenure: no grant that cycle, next state IDLE, rr_ptr<=owner+1.
REQ-027 fifo_full high SHALL suppress all grants without changing state, owner, beat_cnt or rr_ptr; the burst resumes when full drops.
REQ-028 fifo_wr_en SHALL equal |gnt, and fifo_wdata SHALL equal the granted slice (owner's slice in BURST), else 0.
REQ-029 fifo_rd_en SHALL equal rd_req&!fifo_empty, independent of the write side (simultaneous read and write allowed).
REQ-030 fifo_full&&fifo_empty SHALL force gnt=0 and fifo_rd_en=0 in that cycle and set flag_err, which clears only on reset.
REQ-031 gnt SHALL always be one-hot or zero, and fifo_wr_en SHALL never be high while fifo_full is high.

Reset
REQ-032 While rst=0, the block SHALL be in IDLE with rr_ptr=0, owner=0, beat_cnt=0, flag_err=0 and stall_cnt=0, and SHALL drive gnt=0, fifo_wr_en=0, fifo_wdata=0 and fifo_rd_en=0 immediately, independent of clk.
REQ-033 Reset asserted mid-burst SHALL abandon the tenure; the first post-reset arbitration SHALL start from requester 0.

Configuration
REQ-034 When macro FIFO_ARB_STALL_CNT_EN is defined, stall_cnt SHALL increment on each cycle where |req && fifo_full, and SHALL saturate at 16'hFFFF.
REQ-035 When FIFO_ARB_STALL_CNT_EN is undefined, stall_cnt SHALL be tied to 0 and no counter logic SHALL exist; all other behaviour is identical.

Verification
REQ-036 Scenario: NREQ=4, req=4'b1111 held, last=4'b1111 -> grants 0,1,2,3,0 on consecutive cycles, one beat each.
REQ-037 Scenario: req[2] alone with last low for 6 cycles, MAX_BURST=4 -> 4 beats to requester 2, one IDLE re-arbitration cycle that regrants 2, then beats continue.
REQ-038 Scenario: fifo_full raised during the 2nd beat of a burst by requester 1 for 3 cycles -> gnt=0 and fifo_wr_en=0 for those 3 cycles, then the burst resumes at beat_cnt=2 with owner still 1.
REQ-039 Scenario: rd_req=1 with fifo_empty=1 -> fifo_rd_en=0; with fifo_empty=0 -> fifo_rd_en=1 in the same cycle.
REQ-040 Scenario: full=1 and empty=1 together for 1 cycle -> flag_err=1 held; gnt=0 and fifo_rd_en=0 in that cycle.
REQ-041 Scenario: rst pulled low mid-burst by requester 3, then released with req=4'b1001 -> requester 0 granted first; with FIFO_ARB_STALL_CNT_EN defined, 5 full-stall cycles -> stall_cnt=5.
